// File: rtl/sort4_seq_pkg.sv
// sort4_seq_pkg
//   Shared definitions for the sort4_seq block-sorter slice.
//   - W_DEF / N_DEF : default operand width and block length
//   - sort_state_e  : controller state encoding (LOAD / SORT / OUT)
package sort4_seq_pkg;

  localparam int W_DEF = 4;
  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_OUT  = 2'd2
  } sort_state_e;

endpackage

// File: rtl/sort4_seq_cmp_flags.sv
// sort4_seq_cmp_flags
//   Combinational W-bit magnitude comparator built on a single subtraction
//   a - b. Produces unsigned (ug/ul), equality (eq) and two's complement
//   signed (sg/sl) flags.
//   Ports:
//     a_i, b_i : operands (W bits)
//     ug_o/ul_o: a > b / a < b, unsigned
//     eq_o     : a == b
//     sg_o/sl_o: a > b / a < b, signed
module sort4_seq_cmp_flags #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         ug_o,
  output logic         ul_o,
  output logic         eq_o,
  output logic         sg_o,
  output logic         sl_o
);

  logic [W:0] diff;
  logic       borrow;
  logic       zero;
  logic       neg;
  logic       ovf;

  // Zero-extended subtract: bit W is the borrow out (a < b unsigned).
  assign diff   = {1'b0, a_i} - {1'b0, b_i};
  assign borrow = diff[W];
  assign zero   = (diff[W-1:0] == '0);
  assign neg    = diff[W-1];
  // Signed overflow: operands differ in sign and the result sign differs
  // from a. Then the raw sign bit is wrong, so signed less-than is neg^ovf
  // (this is what makes 7 vs -8 come out as 7 greater).
  assign ovf    = (a_i[W-1] ^ b_i[W-1]) & (a_i[W-1] ^ neg);

  assign eq_o = zero;
  assign ul_o = borrow;
  assign ug_o = ~borrow & ~zero;
  assign sl_o = neg ^ ovf;
  assign sg_o = ~(neg ^ ovf) & ~zero;

endmodule

// File: rtl/sort4_seq.sv
// sort4_seq
//   Loads a block of N words, bubble-sorts them in place with one compare
//   per cycle (stable: equal words never swap), then streams them out in
//   ascending order under either unsigned or signed interpretation.
//   Ports:
//     clk, rstn           : clock, synchronous active-low reset
//     sgn                 : 0 unsigned, 1 signed; latched on first word of a block
//     in_valid/in_ready   : input stream handshake, in_data is the word
//     out_valid/out_ready : output stream handshake, out_data is the word
//     out_last            : marks the N-th output word
//     busy                : high while sorting
//     npass               : completed bubble passes for the current block
//     dbg_state           : current controller state
//   Handshake: a word transfers on a rising clk edge where valid and ready
//   are both high; a valid producer holds its data stable until it transfers,
//   and ready never depends combinationally on valid.
module sort4_seq
  import sort4_seq_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sgn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [$clog2(N):0]     npass,
  output sort_state_e            dbg_state
);

  localparam int CW  = $clog2(N);
  localparam int NPW = $clog2(N) + 1;

  sort_state_e    state_q;
  logic [W-1:0]   mem_q [N];
  logic [CW-1:0]  lcnt_q;
  logic [CW-1:0]  ocnt_q;
  logic [CW-1:0]  idx_q;
  logic [CW-1:0]  idx_nx;
  logic           swapped_q;
  logic [NPW-1:0] npass_q;
  logic           sgn_q;

  logic [W-1:0]   cmp_a;
  logic [W-1:0]   cmp_b;
  logic           ug, ul, eq, sg, sl;
  logic           greater;

  assign idx_nx = idx_q + CW'(1);
  assign cmp_a  = mem_q[idx_q];
  assign cmp_b  = mem_q[idx_nx];

  sort4_seq_cmp_flags #(.W(W)) u_cmp_flags (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .ug_o (ug),
    .ul_o (ul),
    .eq_o (eq),
    .sg_o (sg),
    .sl_o (sl)
  );

  // The flags are mutually exclusive, so qualifying "greater" with the
  // less/equal flags never changes it; it only guards against a broken
  // comparator ever swapping an equal or smaller pair.
  assign greater = sgn_q ? (sg & ~sl & ~eq) : (ug & ~ul & ~eq);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_LOAD;
      lcnt_q    <= '0;
      ocnt_q    <= '0;
      idx_q     <= '0;
      swapped_q <= 1'b0;
      npass_q   <= '0;
      sgn_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            mem_q[lcnt_q] <= in_data;
            if (lcnt_q == '0) begin
              sgn_q   <= sgn;
              npass_q <= '0;
            end
            if (lcnt_q == CW'(N-1)) begin
              lcnt_q    <= '0;
              idx_q     <= '0;
              swapped_q <= 1'b0;
              state_q   <= ST_SORT;
            end else begin
              lcnt_q <= lcnt_q + CW'(1);
            end
          end
        end
        ST_SORT: begin
          if (greater) begin
            mem_q[idx_q]  <= cmp_b;
            mem_q[idx_nx] <= cmp_a;
          end
          if (idx_q == CW'(N-2)) begin
            // End of a pass: the swap of this very cycle counts too.
            npass_q   <= npass_q + NPW'(1);
            idx_q     <= '0;
            swapped_q <= 1'b0;
            if (!(swapped_q || greater)) begin
              state_q <= ST_OUT;
            end
          end else begin
            idx_q     <= idx_nx;
            swapped_q <= swapped_q | greater;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (ocnt_q == CW'(N-1)) begin
              ocnt_q  <= '0;
              state_q <= ST_LOAD;
            end else begin
              ocnt_q <= ocnt_q + CW'(1);
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // Outputs are decoded from registered state; reset forces them low at once.
  assign in_ready  = rstn && (state_q == ST_LOAD);
  assign busy      = rstn && (state_q == ST_SORT);
  assign out_valid = rstn && (state_q == ST_OUT);
  assign out_last  = out_valid && (ocnt_q == CW'(N-1));
  assign out_data  = out_valid ? mem_q[ocnt_q] : '0;
  assign npass     = npass_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sort4_seq.sv
module tb_sort4_seq;
  import sort4_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn;
  logic        sgn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_last;
  logic        busy;
  logic [2:0]  npass;
  sort_state_e dbg_state;

  always #5 clk = ~clk;

  sort4_seq #(.W(4), .N(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sgn       (sgn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .npass     (npass),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [3:0] exp_q[$];
  logic [2:0] exp_npass;
  logic [3:0] blk [4];
  logic [3:0] obs_d [4];
  logic [3:0] obs_l;
  int         sort_cyc;
  int         hold_err;
  int         hs_cnt;
  bit         timed_out;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] e;

  // Reference bubble sort: pushes the sorted block and the pass count.
  task automatic model_push(input bit s);
    logic [3:0] a [4];
    logic [3:0] t;
    bit         sw;
    bit         gt;
    int         passes;
    for (int i = 0; i < 4; i++) a[i] = blk[i];
    passes = 0;
    do begin
      sw = 1'b0;
      for (int j = 0; j < 3; j++) begin
        gt = s ? ($signed(a[j]) > $signed(a[j+1])) : (a[j] > a[j+1]);
        if (gt) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t; sw = 1'b1;
        end
      end
      passes++;
    end while (sw);
    for (int i = 0; i < 4; i++) exp_q.push_back(a[i]);
    exp_npass = 3'(passes);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the last accept.
  // sgn is flipped after the first word to show it is latched once.
  task automatic send_block(input bit s);
    int g;
    timed_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      sgn      = (i == 0) ? s : ~s;
      g = 0;
      while (in_ready !== 1'b1 && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) timed_out = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  // Counts SORT cycles and drains N words; mode 1 uses ready 1,0,0,1,0,0...
  task automatic collect(input bit mode);
    int   cyc;
    int   k;
    bit   prev_stall;
    logic [3:0] held;
    cyc = 0; k = 0; prev_stall = 1'b0; held = '0;
    sort_cyc = 0; hold_err = 0; hs_cnt = 0; obs_l = '0;
    while (hs_cnt < 4 && cyc < 300) begin
      if (busy === 1'b1) sort_cyc++;
      if (out_valid === 1'b1) begin
        out_ready = mode ? (k % 3 == 0) : 1'b1;
        k++;
        if (prev_stall && out_data !== held) hold_err++;
        if (out_ready) begin
          obs_d[hs_cnt] = out_data;
          obs_l[hs_cnt] = out_last;
          hs_cnt++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          held = out_data;
        end
      end else begin
        out_ready = ~mode;
      end
      @(negedge clk);
      cyc++;
    end
    if (hs_cnt < 4) timed_out = 1'b1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (out_data !== 4'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_tests++; if (npass !== 3'd0) begin n_fail++; $display("FAIL reset_npass: got %0d want 0", npass); end
    rstn = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
    n_tests++; if (dbg_state !== ST_LOAD) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_LOAD); end
  endtask

  task automatic test_unsigned;
    blk = '{4'd3, 4'd1, 4'd2, 4'd0};
    model_push(1'b0);
    send_block(1'b0);
    collect(1'b0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL unsigned_done: got %0d words want 4", hs_cnt); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (obs_d[i] !== e) begin n_fail++; $display("FAIL unsigned_word%0d: got %0d want %0d", i, obs_d[i], e); end
    end
    n_tests++; if (obs_l !== 4'b1000) begin n_fail++; $display("FAIL unsigned_last: got %b want 1000", obs_l); end
    n_tests++; if (npass !== exp_npass) begin n_fail++; $display("FAIL unsigned_npass: got %0d want %0d", npass, exp_npass); end
    n_tests++; if (sort_cyc !== 3 * int'(exp_npass)) begin n_fail++; $display("FAIL unsigned_sort_cycles: got %0d want %0d", sort_cyc, 3 * int'(exp_npass)); end
  endtask

  task automatic test_signed;
    for (int m = 1; m >= 0; m--) begin
      blk = '{4'd7, 4'd8, 4'd15, 4'd0};
      model_push(m[0]);
      send_block(m[0]);
      collect(1'b0);
      n_tests++; if (timed_out) begin n_fail++; $display("FAIL signed_done mode%0d: got %0d words want 4", m, hs_cnt); end
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front();
        n_tests++; if (obs_d[i] !== e) begin n_fail++; $display("FAIL signed_word%0d mode%0d: got %0d want %0d", i, m, obs_d[i], e); end
      end
      n_tests++; if (npass !== exp_npass) begin n_fail++; $display("FAIL signed_npass mode%0d: got %0d want %0d", m, npass, exp_npass); end
    end
  endtask

  task automatic test_sorted;
    blk = '{4'd1, 4'd2, 4'd3, 4'd4};
    model_push(1'b0);
    send_block(1'b0);
    collect(1'b0);
    n_tests++; if (sort_cyc !== 3) begin n_fail++; $display("FAIL sorted_sort_cycles: got %0d want 3", sort_cyc); end
    n_tests++; if (npass !== 3'd1) begin n_fail++; $display("FAIL sorted_npass: got %0d want 1", npass); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (obs_d[i] !== e) begin n_fail++; $display("FAIL sorted_word%0d: got %0d want %0d", i, obs_d[i], e); end
    end
  endtask

  task automatic test_duplicates;
    blk = '{4'd5, 4'd2, 4'd5, 4'd2};
    model_push(1'b0);
    send_block(1'b0);
    collect(1'b0);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (obs_d[i] !== e) begin n_fail++; $display("FAIL dup_word%0d: got %0d want %0d", i, obs_d[i], e); end
    end
    // A swap of equal pairs would keep the sort from settling in this many passes.
    n_tests++; if (npass !== exp_npass) begin n_fail++; $display("FAIL dup_npass: got %0d want %0d", npass, exp_npass); end
  endtask

  task automatic test_backpressure;
    blk = '{4'd12, 4'd0, 4'd9, 4'd3};
    model_push(1'b0);
    send_block(1'b0);
    collect(1'b1);
    n_tests++; if (hs_cnt !== 4) begin n_fail++; $display("FAIL bp_handshakes: got %0d want 4", hs_cnt); end
    n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d changes want 0", hold_err); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (obs_d[i] !== e) begin n_fail++; $display("FAIL bp_word%0d: got %0d want %0d", i, obs_d[i], e); end
    end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_after: got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid_after: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_sort;
    blk = '{4'd3, 4'd1, 4'd2, 4'd0};
    send_block(1'b0);
    repeat (5) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_tests++; if (npass !== 3'd0) begin n_fail++; $display("FAIL midrst_npass: got %0d want 0", npass); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    blk = '{4'd9, 4'd4, 4'd6, 4'd1};
    model_push(1'b0);
    send_block(1'b0);
    collect(1'b0);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_tests++; if (obs_d[i] !== e) begin n_fail++; $display("FAIL midrst_word%0d: got %0d want %0d", i, obs_d[i], e); end
    end
  endtask

  task automatic test_random;
    bit s;
    bit m;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) blk[i] = 4'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      model_push(s);
      send_block(s);
      collect(m);
      n_tests++; if (timed_out) begin n_fail++; $display("FAIL rand%0d_done: got %0d words want 4", r, hs_cnt); end
      for (int i = 0; i < 4; i++) begin
        e = exp_q.pop_front();
        n_tests++; if (obs_d[i] !== e) begin n_fail++; $display("FAIL rand%0d_word%0d: got %0d want %0d", r, i, obs_d[i], e); end
      end
      n_tests++; if (npass !== exp_npass) begin n_fail++; $display("FAIL rand%0d_npass: got %0d want %0d", r, npass, exp_npass); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rstn      = 1'b0;
    sgn       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_sorted();
    test_duplicates();
    test_backpressure();
    test_reset_mid_sort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
